// File: rtl/median_window_gen_pkg.sv
// Shared types and sizing helpers for the median window generator slice.
package median_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int unsigned DEF_NUM_VALS = 7;
  localparam int unsigned DEF_SIZE     = 8;

  function automatic int unsigned half_of(input int unsigned num_vals);
    return (num_vals - 1) / 2;
  endfunction

  function automatic int unsigned push_cnt_w(input int unsigned num_vals);
    return $clog2(num_vals + 1);
  endfunction

  function automatic int unsigned flush_cnt_w(input int unsigned num_vals);
    return $clog2(half_of(num_vals) + 1);
  endfunction

endpackage

// File: rtl/median_window_gen_if.sv
// Sample-in / window-out bundle between the producer, the window generator and the sorter.
interface median_window_gen_if #(
  parameter int unsigned NUM_VALS = 7,
  parameter int unsigned SIZE     = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [SIZE-1:0]          s_data;
  logic                     s_last;
  logic                     win_valid;
  logic [NUM_VALS*SIZE-1:0] win_data;
  logic                     win_last;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, win_valid, win_data, win_last
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, win_valid, win_data, win_last
  );
endinterface

// File: rtl/median_window_gen_shift_reg.sv
// NUM_VALS x SIZE sliding register: slot 0 oldest, top slot newest; exposes next-state bus.
module median_shift_reg #(
  parameter int unsigned NUM_VALS = 7,
  parameter int unsigned SIZE     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load_all,
  input  logic                     i_push,
  input  logic [SIZE-1:0]          i_din,
  output logic [NUM_VALS*SIZE-1:0] o_q,
  output logic [NUM_VALS*SIZE-1:0] o_next
);

  logic [NUM_VALS*SIZE-1:0] r_q;
  logic [NUM_VALS*SIZE-1:0] w_next;

  always_comb begin
    w_next = r_q;
    if (i_load_all)
      w_next = {NUM_VALS{i_din}};
    else if (i_push)
      w_next = {i_din, r_q[NUM_VALS*SIZE-1:SIZE]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else
      r_q <= w_next;
  end

  assign o_q    = r_q;
  assign o_next = w_next;

endmodule

// File: rtl/median_window_gen.sv
// Centred sliding-window generator with edge replication at frame start and end.
module median_window_gen
  import median_pkg::*;
#(
  parameter int unsigned NUM_VALS = DEF_NUM_VALS,
  parameter int unsigned SIZE     = DEF_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  median_window_gen_if.slave bus
);

  localparam int unsigned HALF = half_of(NUM_VALS);
  localparam int unsigned PCW  = push_cnt_w(NUM_VALS);
  localparam int unsigned FCW  = flush_cnt_w(NUM_VALS);
  localparam logic [PCW-1:0] EMIT_CNT   = PCW'(HALF + 1);
  localparam logic [FCW-1:0] LAST_FLUSH = FCW'(HALF - 1);

  state_t                   r_state;
  logic [PCW-1:0]           r_push_cnt;
  logic [FCW-1:0]           r_flush_cnt;
  logic                     r_s_ready;
  logic                     r_win_valid;
  logic                     r_win_last;
  logic [NUM_VALS*SIZE-1:0] r_win_data;

  logic                     w_accept;
  logic                     w_load_all;
  logic                     w_push;
  logic                     w_flush_done;
  logic                     w_emit;
  logic [SIZE-1:0]          w_din;
  logic [PCW-1:0]           w_cnt_next;
  logic [NUM_VALS*SIZE-1:0] w_sr_q;
  logic [NUM_VALS*SIZE-1:0] w_sr_next;

  median_shift_reg #(
    .NUM_VALS (NUM_VALS),
    .SIZE     (SIZE)
  ) u_sr (
    .clk        (clk),
    .rst        (rst),
    .i_load_all (w_load_all),
    .i_push     (w_push),
    .i_din      (w_din),
    .o_q        (w_sr_q),
    .o_next     (w_sr_next)
  );

  // Push count saturates at HALF+1; every push reaching it emits the post-push window.
  always_comb begin
    w_accept     = bus.s_valid & r_s_ready;
    w_load_all   = (r_state == IDLE) & w_accept;
    w_push       = ((r_state == RUN) & w_accept) | (r_state == FLUSH);
    w_din        = (r_state == FLUSH) ? w_sr_q[(NUM_VALS-1)*SIZE +: SIZE] : bus.s_data;
    w_flush_done = (r_state == FLUSH) && (r_flush_cnt == LAST_FLUSH);
    w_cnt_next   = r_push_cnt;
    if (w_load_all)
      w_cnt_next = PCW'(1);
    else if (w_push && (r_push_cnt != EMIT_CNT))
      w_cnt_next = r_push_cnt + 1'b1;
    w_emit = (w_load_all | w_push) && (w_cnt_next == EMIT_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_push_cnt  <= '0;
      r_flush_cnt <= '0;
      r_s_ready   <= 1'b1;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_data  <= '0;
    end else begin
      r_push_cnt  <= w_cnt_next;
      r_win_valid <= w_emit;
      r_win_last  <= w_emit & w_flush_done;
      if (w_emit)
        r_win_data <= w_sr_next;
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            r_state     <= bus.s_last ? FLUSH : RUN;
            r_s_ready   <= ~bus.s_last;
            r_flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (w_flush_done) begin
            r_state    <= IDLE;
            r_s_ready  <= 1'b1;
            r_push_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.win_valid = r_win_valid;
  assign bus.win_last  = r_win_last;
  assign bus.win_data  = r_win_data;

endmodule
